bin_seg_conv: RTL
=================

# bin_seg_conv

Parametrised binary-to-7-segment converter: the successor of the 14-bit/4-digit converter. It sits between the calculator datapath and the display multiplexer. It accepts an IN_W-bit result, unsigned or two's complement, and converts it to BCD by sequential double-dabble, one shift per clock. It then drives N_DIG segment bytes with a ready/done handshake, overflow detection and the "bruh" error pattern.

## Interface
- IN_W, 14: input width in bits, 4..32
- N_DIG, 4: display digits, 4..8
- SIGNED, 0: 1 selects two's-complement input; the most significant display position is reserved for the sign
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- num  in  IN_W  value to convert; sampled only on an accepted start
- convert  in  1  start request; accepted only when ready=1
- error  in  1  show the error pattern; has priority over convert
- seg  out  8*N_DIG  segment word, bit order {dp,g,f,e,d,c,b,a}, active-high
  - seg[7:0] is the most significant position
  - seg[8*N_DIG-1 -: 8] is the ones digit
- ready  out  1  idle, accepting convert/error
- done  out  1  one-cycle pulse when seg/ovf are updated
- ovf  out  1  last result did not fit; valid from done, held until next done

## Operation
- Reset values: seg=0, ready=1, done=0, ovf=0, state=IDLE.
- **States:**
  - IDLE: ready=1.
    - error=1 → ERR.
    - Otherwise convert=1 → SHIFT. Load magnitude (|num| if SIGNED, else num), latch sign, clear BCD register, clear shift counter.
  - SHIFT: ready=0.
    - Each cycle, add 3 to every BCD nibble ≥5, then shift {bcd,mag} left by 1.
    - After IN_W shifts → FORMAT.
    - error=1 during SHIFT aborts the conversion → ERR.
  - FORMAT: register seg and ovf, pulse done, → IDLE.
  - ERR: seg = error pattern, ovf=0, pulse done, → IDLE.
- **BCD register:** BCD_DIG nibbles, where BCD_DIG = ceil(IN_W·log10 2).
- **Available numeric positions:** P = N_DIG − SIGNED.
- **Overflow:** any BCD nibble at index ≥ P is nonzero. Then ovf=1 and seg = error pattern.
- **Error pattern:** b,r,u,h in positions 0..3, i.e. seg[31:0]=32'h741C507C. Any positions above 3 are 0x00.
- **Digit encoding:** 0..9 → 3F,06,5B,4F,66,6D,7D,07,7F,6F. Minus sign = 0x40.
- **Sign position:** with SIGNED=1, position 0 holds 0x40 if negative, 0x00 if positive or zero.
- **Negative extreme:** the most negative input −2^(IN_W−1) converts its magnitude exactly; no wrap.
- **Busy behaviour:** convert asserted while ready=0 is ignored and is not queued.

## Timing
- **Accept edge:** convert is accepted at edge E0.
- **Shifts:** occur at edges E1..E(IN_W).
- **Result:** at E(IN_W+1), seg/ovf update, done=1 and ready=1.
- **Latency:** start to done is IN_W+1 cycles; done falls at the next edge.
- **Back-to-back:** a convert in the same cycle as done is accepted, giving a throughput of IN_W+2 cycles per conversion.
- **Error from IDLE:** error sampled at E0 → seg/done at E1.
- **Error during SHIFT:** error sampled at edge Ek → error pattern and done at Ek+1. No numeric done follows.
- **rst mid-operation:** at the next edge all outputs return to reset values. The aborted conversion never raises done.
- **Output hold:** seg is held unchanged between done pulses.

## Configuration
- **Macro:** SEG_LZ_BLANK_EN.
- **Defined:** leading zero positions output 0x00.
  - A value of 0 shows a single 0x3F in the ones position.
  - With SIGNED, the minus sign moves to the position immediately left of the most significant nonzero digit; position 0 is blank unless it is that position.
- **Undefined:** all P numeric positions show digits, including leading zeros, and the sign stays in position 0.
- **Error pattern:** unaffected in both cases.

## Structure
- **Package seg_pkg** holds:
  - state enum {IDLE, SHIFT, FORMAT, ERR};
  - segment constants for digits 0..9, minus and blank;
  - ERR_PATTERN = 32'h741C507C;
  - the BCD_DIG width function.
- **Sub-module seg_digit_enc:** combinational, nibble plus blank input → segment byte. One instance per position via generate.

## Test plan
- **Basic conversion:** IN_W=14, N_DIG=4, SIGNED=0, num=1234, convert → done exactly 15 cycles after the accept edge, seg=32'h664F5B06, ovf=0.
- **Overflow:** num=12345 → done, ovf=1, seg=32'h741C507C.
- **Leading-zero blanking:** num=7 → seg=32'h07000000 with SEG_LZ_BLANK_EN, seg=32'h073F3F3F without.
- **Signed:** SIGNED=1, num=−42 (14'h3FD6) → seg=32'h5B663F40 without blanking, 32'h5B664000 with blanking. Then num=−1000 → ovf=1.
- **Priority and abort:**
  - error and convert asserted in the same cycle → error pattern at the next edge, no numeric result.
  - error asserted on the 5th SHIFT cycle → error pattern and done one cycle later.
- **Reset and busy:**
  - rst on the 5th SHIFT cycle → seg=0, ready=1, done stays 0.
  - convert pulses while ready=0 are ignored.
  - back-to-back converts at each done yield one done per IN_W+2 cycles.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and constants for the binary-to-7-segment converter.
// Segment bytes are {dp,g,f,e,d,c,b,a}, active-high.
package seg_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, FORMAT, ERR} state_t;

  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6D;
  localparam logic [7:0] SEG_6     = 8'h7D;
  localparam logic [7:0] SEG_7     = 8'h07;
  localparam logic [7:0] SEG_8     = 8'h7F;
  localparam logic [7:0] SEG_9     = 8'h6F;
  localparam logic [7:0] SEG_MINUS = 8'h40;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  // "bruh": b,r,u,h in display positions 0..3
  localparam logic [31:0] ERR_PATTERN = 32'h741C507C;

  // Nibble code the formatter uses to request a minus sign from the encoder
  localparam logic [3:0] NIB_MINUS = 4'hA;

  // Decimal digits needed for a w-bit unsigned value: ceil(w*log10(2))
  function automatic int bcd_dig(input int w);
    return (w * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bin_seg_conv_if.sv
// Request/result bundle between the calculator datapath and bin_seg_conv.
interface bin_seg_conv_if #(
  parameter int IN_W  = 14,
  parameter int N_DIG = 4
);
  logic [IN_W-1:0]    num;
  logic               convert;
  logic               error;
  logic [8*N_DIG-1:0] seg;
  logic               ready;
  logic               done;
  logic               ovf;

  modport master (output num, convert, error, input seg, ready, done, ovf);
  modport slave  (input num, convert, error, output seg, ready, done, ovf);
endinterface

// File: rtl/seg_digit_enc.sv
// One display position: BCD nibble (or minus code) to segment byte.
module seg_digit_enc
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       blank,
  output logic [7:0] seg
);
  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (nib)
        4'd0:      seg = SEG_0;
        4'd1:      seg = SEG_1;
        4'd2:      seg = SEG_2;
        4'd3:      seg = SEG_3;
        4'd4:      seg = SEG_4;
        4'd5:      seg = SEG_5;
        4'd6:      seg = SEG_6;
        4'd7:      seg = SEG_7;
        4'd8:      seg = SEG_8;
        4'd9:      seg = SEG_9;
        NIB_MINUS: seg = SEG_MINUS;
        default:   seg = SEG_BLANK;
      endcase
    end
  end
endmodule

// File: rtl/bin_seg_conv.sv
// Sequential double-dabble binary-to-7-segment converter with overflow and error pattern.
// Optional SEG_LZ_BLANK_EN: blank leading zeros and float the minus sign next to the top digit.
module bin_seg_conv
  import seg_pkg::*;
#(
  parameter int IN_W   = 14,
  parameter int N_DIG  = 4,
  parameter int SIGNED = 0
) (
  input  logic           clk,
  input  logic           rst,
  bin_seg_conv_if.slave  bus
);
  localparam int BCD_DIG = bcd_dig(IN_W);
  localparam int BW      = 4 * BCD_DIG;
  localparam int P       = N_DIG - SIGNED;
  localparam int PAD     = ((BCD_DIG > N_DIG) ? BCD_DIG : N_DIG) + 1;
  localparam int PW      = 4 * PAD;
  localparam int CW      = $clog2(IN_W + 1);
  localparam int SW      = 8 * N_DIG;

  state_t              state;
  logic [IN_W-1:0]     mag;
  logic [BW-1:0]       bcd, bcd_adj;
  logic [CW-1:0]       cnt;
  logic                neg;
  logic [PW-1:0]       bcd_pad;
  logic                ovf_c;
  logic [N_DIG-1:0][3:0] enc_nib;
  logic [N_DIG-1:0]      enc_blank;
  logic [N_DIG-1:0][7:0] enc_seg;

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < BCD_DIG; i++)
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
  end

  // Padding lets every display position index a nibble, even beyond BCD_DIG
  assign bcd_pad = PW'(bcd);
  assign ovf_c   = |bcd_pad[PW-1:4*P];

`ifdef SEG_LZ_BLANK_EN
  always_comb begin
    logic [PAD:1] uz;  // uz[d]: every nibble at index >= d is zero
    uz      = '0;
    uz[PAD] = 1'b1;
    for (int d = PAD - 1; d >= 1; d--)
      uz[d] = uz[d+1] & (bcd_pad[4*d +: 4] == 4'd0);
    enc_nib   = '0;
    enc_blank = '0;
    for (int d = 0; d < N_DIG; d++) begin
      enc_nib[N_DIG-1-d] = bcd_pad[4*d +: 4];
      if (d >= P) begin
        enc_nib[N_DIG-1-d]   = NIB_MINUS;
        enc_blank[N_DIG-1-d] = !(neg && bcd_pad[4*(d-1) +: 4] != 4'd0);
      end else if (d > 0 && uz[d]) begin
        if (neg && bcd_pad[4*(d-1) +: 4] != 4'd0) enc_nib[N_DIG-1-d] = NIB_MINUS;
        else                                      enc_blank[N_DIG-1-d] = 1'b1;
      end
    end
  end
`else
  always_comb begin
    enc_nib   = '0;
    enc_blank = '0;
    for (int d = 0; d < N_DIG; d++) begin
      enc_nib[N_DIG-1-d] = bcd_pad[4*d +: 4];
      if (d >= P) begin
        enc_nib[N_DIG-1-d]   = NIB_MINUS;
        enc_blank[N_DIG-1-d] = !neg;
      end
    end
  end
`endif

  for (genvar p = 0; p < N_DIG; p++) begin : g_pos
    seg_digit_enc u_enc (.nib(enc_nib[p]), .blank(enc_blank[p]), .seg(enc_seg[p]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bus.seg   <= '0;
      bus.ready <= 1'b1;
      bus.done  <= 1'b0;
      bus.ovf   <= 1'b0;
      mag       <= '0;
      bcd       <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.error) begin
            state     <= ERR;
            bus.ready <= 1'b0;
          end else if (bus.convert) begin
            state     <= SHIFT;
            bus.ready <= 1'b0;
            // Negating the most negative value yields 2^(IN_W-1) read as unsigned
            mag <= ((SIGNED != 0) && bus.num[IN_W-1]) ? IN_W'(-bus.num) : bus.num;
            neg <= (SIGNED != 0) && bus.num[IN_W-1];
            bcd <= '0;
            cnt <= '0;
          end
        end
        SHIFT: begin
          if (bus.error) begin
            state <= ERR;
          end else begin
            bcd <= BW'({bcd_adj, mag[IN_W-1]});
            mag <= mag << 1;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(IN_W - 1)) state <= FORMAT;
          end
        end
        FORMAT: begin
          bus.seg   <= ovf_c ? SW'(ERR_PATTERN) : enc_seg;
          bus.ovf   <= ovf_c;
          bus.done  <= 1'b1;
          bus.ready <= 1'b1;
          state     <= IDLE;
        end
        ERR: begin
          bus.seg   <= SW'(ERR_PATTERN);
          bus.ovf   <= 1'b0;
          bus.done  <= 1'b1;
          bus.ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
